// File: rtl/game_sequencer.sv
// game_sequencer: game-state controller for a side-scrolling bird game.
//
// Synchronises the three push buttons, produces a one-cycle frame tick at
// the start of vertical blanking, runs the IDLE/PLAY/DEAD state machine,
// keeps the score and an animation counter, and qualifies the up/down
// commands so that they are only active while playing.
//
// Ports:
//   clk        pixel clock (only clock)
//   rst        asynchronous active-high reset
//   btn_start  start/restart button (asynchronous)
//   btn_up     up button (asynchronous)
//   btn_down   down button (asynchronous)
//   pos_x      current scan x
//   pos_y      current scan y
//   isbird     current pixel is a bird pixel
//   ispipe     current pixel is a pipe pixel
//   birdy      bird top-edge y
//   pipe_pass  one-cycle pulse when a pipe clears the bird
//   state      one-hot game state: IDLE=001, PLAY=010, DEAD=100
//   count      animation frame counter (wraps after ANIM_MAX)
//   frameclk   one-cycle frame tick
//   up         qualified up command
//   down       qualified down command (up has priority)
//   score      pipes passed, saturating at 255
//   crash      one-cycle pulse on entry to DEAD
module game_sequencer #(
  parameter int V_ACTIVE    = 900,
  parameter int FLOOR_Y     = 810,
  parameter int ANIM_MAX    = 59,
  parameter int DEAD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [10:0] pos_x,
  input  logic [10:0] pos_y,
  input  logic        isbird,
  input  logic        ispipe,
  input  logic [10:0] birdy,
  input  logic        pipe_pass,
  output logic [2:0]  state,
  output logic [5:0]  count,
  output logic        frameclk,
  output logic        up,
  output logic        down,
  output logic [7:0]  score,
  output logic        crash
);

  localparam int DW = $clog2(DEAD_FRAMES + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_PLAY = 3'b010,
    ST_DEAD = 3'b100
  } state_t;

  state_t        state_r;
  logic          start_s1_r, start_s2_r, start_prev_r;
  logic          up_s1_r, up_s2_r;
  logic          down_s1_r, down_s2_r;
  logic [DW-1:0] dead_cnt_r;
  logic [5:0]    count_r;
  logic          frameclk_r;
  logic          up_r, down_r, crash_r;
  logic [7:0]    score_r;

  logic          start_edge_s;
  logic          hit_s;
  logic          frame_pos_s;

  // Start edge, crash condition and frame-position decode.
  always_comb begin
    start_edge_s = start_s2_r & ~start_prev_r;
    // birdy[10] set means the bird moved above the top and underflowed.
    hit_s        = (isbird & ispipe) | (birdy >= 11'(FLOOR_Y)) | birdy[10];
    frame_pos_s  = (pos_x == 11'd0) && (pos_y == 11'(V_ACTIVE));
  end

  // Two-flop synchronisers for the asynchronous buttons, plus start history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_s1_r   <= 1'b0;
      start_s2_r   <= 1'b0;
      start_prev_r <= 1'b0;
      up_s1_r      <= 1'b0;
      up_s2_r      <= 1'b0;
      down_s1_r    <= 1'b0;
      down_s2_r    <= 1'b0;
    end else begin
      start_s1_r   <= btn_start;
      start_s2_r   <= start_s1_r;
      start_prev_r <= start_s2_r;
      up_s1_r      <= btn_up;
      up_s2_r      <= up_s1_r;
      down_s1_r    <= btn_down;
      down_s2_r    <= down_s1_r;
    end
  end

  // Frame tick and free-running animation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frameclk_r <= 1'b0;
      count_r    <= 6'd0;
    end else begin
      frameclk_r <= frame_pos_s;
      if (frameclk_r) begin
        if (count_r == 6'(ANIM_MAX)) begin
          count_r <= 6'd0;
        end else begin
          count_r <= count_r + 6'd1;
        end
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Game state machine with score, dead counter and qualified commands.
  // up/down follow the state being entered so they drop together with PLAY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      score_r    <= 8'd0;
      dead_cnt_r <= '0;
      up_r       <= 1'b0;
      down_r     <= 1'b0;
      crash_r    <= 1'b0;
    end else begin
      crash_r <= 1'b0;
      up_r    <= 1'b0;
      down_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_edge_s) begin
            state_r <= ST_PLAY;
            score_r <= 8'd0;
            up_r    <= up_s2_r;
            down_r  <= down_s2_r & ~up_s2_r;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_PLAY: begin
          // A crash wins over a simultaneous pipe_pass: score is frozen.
          if (hit_s) begin
            state_r    <= ST_DEAD;
            crash_r    <= 1'b1;
            dead_cnt_r <= '0;
          end else begin
            state_r <= ST_PLAY;
            up_r    <= up_s2_r;
            down_r  <= down_s2_r & ~up_s2_r;
            if (pipe_pass && (score_r != 8'd255)) begin
              score_r <= score_r + 8'd1;
            end else begin
              score_r <= score_r;
            end
          end
        end
        ST_DEAD: begin
          if (start_edge_s && (dead_cnt_r == DW'(DEAD_FRAMES))) begin
            state_r <= ST_IDLE;
          end else if (frameclk_r && (dead_cnt_r != DW'(DEAD_FRAMES))) begin
            dead_cnt_r <= dead_cnt_r + DW'(1);
          end else begin
            state_r <= ST_DEAD;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign state    = state_r;
  assign count    = count_r;
  assign frameclk = frameclk_r;
  assign up       = up_r;
  assign down     = down_r;
  assign score    = score_r;
  assign crash    = crash_r;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed, table-driven bench for game_sequencer.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_start, btn_up, btn_down;
  logic [10:0] pos_x, pos_y, birdy;
  logic        isbird, ispipe, pipe_pass;
  logic [2:0]  state;
  logic [5:0]  count;
  logic        frameclk, up, down, crash;
  logic [7:0]  score;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulses = 0;

  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_PLAY = 3'b010;
  localparam logic [2:0] S_DEAD = 3'b100;

  game_sequencer dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_up(btn_up),
    .btn_down(btn_down), .pos_x(pos_x), .pos_y(pos_y), .isbird(isbird),
    .ispipe(ispipe), .birdy(birdy), .pipe_pass(pipe_pass), .state(state),
    .count(count), .frameclk(frameclk), .up(up), .down(down),
    .score(score), .crash(crash)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        isbird;
    logic        ispipe;
    logic [10:0] birdy;
    logic        pipe_pass;
    logic [2:0]  exp_state;
    logic        exp_crash;
    logic [7:0]  exp_score;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_start = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    pos_x = 11'd5; pos_y = 11'd0; birdy = 11'd100;
    isbird = 1'b0; ispipe = 1'b0; pipe_pass = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic go_play();
    btn_start = 1'b1;
    for (int i = 0; i < 10 && state !== S_PLAY; i++) step();
    chk("go_play", state, S_PLAY);
    btn_start = 1'b0;
    step(); step(); step();
  endtask

  // One frame scan: tick position for one cycle, then off.
  task automatic frame();
    pos_x = 11'd0; pos_y = 11'd900;
    step();
    pos_x = 11'd5; pos_y = 11'd0;
    chk("frameclk_high", frameclk, 1'b1);
    if (frameclk === 1'b1) pulses++;
    step();
    chk("frameclk_low", frameclk, 1'b0);
  endtask

  // Press start long enough to be synchronised, then release.
  task automatic press_start();
    btn_start = 1'b1;
    step(); step(); step(); step();
    btn_start = 1'b0;
    step(); step(); step();
  endtask

  initial begin
    int cyc;
    logic [7:0] held;

    //                isbird ispipe birdy    pp    state   crash score
    vecs[0] = '{1'b1, 1'b0, 11'd100,  1'b0, S_PLAY, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 1'b1, 11'd100,  1'b0, S_PLAY, 1'b0, 8'd0};
    vecs[2] = '{1'b1, 1'b1, 11'd100,  1'b0, S_DEAD, 1'b1, 8'd0};
    vecs[3] = '{1'b0, 1'b0, 11'd810,  1'b0, S_DEAD, 1'b1, 8'd0};
    vecs[4] = '{1'b0, 1'b0, 11'd2040, 1'b0, S_DEAD, 1'b1, 8'd0};
    vecs[5] = '{1'b0, 1'b0, 11'd809,  1'b0, S_PLAY, 1'b0, 8'd0};
    vecs[6] = '{1'b0, 1'b0, 11'd1024, 1'b0, S_DEAD, 1'b1, 8'd0};
    vecs[7] = '{1'b0, 1'b0, 11'd100,  1'b1, S_PLAY, 1'b0, 8'd1};
    vecs[8] = '{1'b1, 1'b1, 11'd100,  1'b1, S_DEAD, 1'b1, 8'd0};

    // Reset values while rst is held.
    rst = 1'b1;
    btn_start = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    pos_x = 11'd5; pos_y = 11'd0; birdy = 11'd100;
    isbird = 1'b0; ispipe = 1'b0; pipe_pass = 1'b0;
    step(); step();
    chk("rst_state", state, S_IDLE);
    chk("rst_count", count, 6'd0);
    chk("rst_frameclk", frameclk, 1'b0);
    chk("rst_up", up, 1'b0);
    chk("rst_down", down, 1'b0);
    chk("rst_score", score, 8'd0);
    chk("rst_crash", crash, 1'b0);
    rst = 1'b0;
    step();

    // pipe_pass in IDLE has no effect; start latency is sync + edge + state.
    pipe_pass = 1'b1; step(); pipe_pass = 1'b0;
    chk("idle_no_score", score, 8'd0);
    btn_start = 1'b1;
    cyc = 0;
    while (state !== S_PLAY && cyc < 10) begin
      step();
      cyc++;
    end
    chk("start_latency", cyc, 3);
    chk("start_state", state, S_PLAY);
    chk("start_score", score, 8'd0);
    btn_start = 1'b0;
    step(); step(); step();

    // Start ignored in PLAY.
    press_start();
    chk("play_ignore_start", state, S_PLAY);

    // Score: 3 passes then saturation.
    for (int i = 0; i < 3; i++) begin
      pipe_pass = 1'b1; step(); pipe_pass = 1'b0; step();
    end
    chk("score_3", score, 8'd3);
    for (int i = 0; i < 300; i++) begin
      pipe_pass = 1'b1; step(); pipe_pass = 1'b0; step();
    end
    chk("score_sat", score, 8'd255);

    // Up/down qualification and priority.
    btn_up = 1'b1; btn_down = 1'b1;
    step(); step(); step(); step();
    chk("up_both", up, 1'b1);
    chk("down_both", down, 1'b0);
    btn_up = 1'b0;
    step(); step(); step(); step();
    chk("up_downonly", up, 1'b0);
    chk("down_downonly", down, 1'b1);
    btn_up = 1'b1;
    step(); step(); step(); step();

    // Pipe hit with buttons held: DEAD, crash pulse, commands dropped.
    isbird = 1'b1; ispipe = 1'b1;
    step();
    isbird = 1'b0; ispipe = 1'b0;
    chk("hit_state", state, S_DEAD);
    chk("hit_crash", crash, 1'b1);
    chk("hit_up", up, 1'b0);
    chk("hit_down", down, 1'b0);
    step();
    chk("hit_crash_end", crash, 1'b0);
    chk("dead_score_hold", score, 8'd255);
    btn_up = 1'b0; btn_down = 1'b0;

    // Dead timer: early presses ignored, accepted once 60 frames elapsed.
    for (int i = 0; i < 10; i++) frame();
    press_start();
    chk("dead_10_press", state, S_DEAD);
    for (int i = 0; i < 49; i++) frame();
    press_start();
    chk("dead_59_press", state, S_DEAD);
    frame();
    press_start();
    chk("dead_60_press", state, S_IDLE);
    chk("idle_score_hold", score, 8'd255);
    go_play();
    chk("replay_score_clear", score, 8'd0);

    // Reset mid-PLAY: IDLE at once, no crash.
    rst = 1'b1;
    #1;
    chk("rst_play_state", state, S_IDLE);
    chk("rst_play_crash", crash, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("rst_play_after", state, S_IDLE);

    // Reset mid-DEAD.
    go_play();
    birdy = 11'd900; step(); birdy = 11'd100;
    chk("pre_rst_dead", state, S_DEAD);
    step();
    rst = 1'b1;
    #1;
    chk("rst_dead_state", state, S_IDLE);
    step();
    rst = 1'b0;
    step();

    // Table of single-cycle crash/score vectors, each from a fresh PLAY.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      go_play();
      isbird = vecs[v].isbird; ispipe = vecs[v].ispipe;
      birdy = vecs[v].birdy; pipe_pass = vecs[v].pipe_pass;
      step();
      isbird = 1'b0; ispipe = 1'b0; birdy = 11'd100; pipe_pass = 1'b0;
      chk($sformatf("vec%0d_state", v), state, vecs[v].exp_state);
      chk($sformatf("vec%0d_crash", v), crash, vecs[v].exp_crash);
      chk($sformatf("vec%0d_score", v), score, vecs[v].exp_score);
      step();
      chk($sformatf("vec%0d_crash_end", v), crash, 1'b0);
    end

    // 61 frames: pulse count and wrap 59 -> 0.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 59; i++) frame();
    chk("count_59", count, 6'd59);
    frame();
    chk("count_wrap", count, 6'd0);
    frame();
    chk("count_61", count, 6'd1);
    chk("frame_pulses", pulses, 61);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
